// File: rtl/mux2x1_rr_arbiter_pkg.sv
// mux2x1_rr_arbiter_pkg: shared state encodings, counter type and helpers for the arbitrated 2:1 mux
package mux2x1_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_inc(input cnt_t c, input cnt_t lim);
        return (c >= lim) ? lim : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mux2x1_rr_arbiter_if.sv
// mux2x1_rr_arbiter_if: request/data/grant bundle between two requesters and the arbitrated mux
interface mux2x1_rr_arbiter_if #(
    parameter int WIDTH = 1
);
    logic [1:0]       req;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [1:0]       gnt;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    modport master (
        output req, a0, a1,
        input  gnt, s, y, y_valid
    );

    modport slave (
        input  req, a0, a1,
        output gnt, s, y, y_valid
    );
endinterface

// File: rtl/mux2x1_rr_arbiter_word.sv
// mux2x1_word: WIDTH-bit combinational 2:1 mux, s=1 selects a1
module mux2x1_word #(
    parameter int WIDTH = 1
) (
    input  logic             s,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] y_comb
);
    assign y_comb = s ? a1 : a0;
endmodule

// File: rtl/mux2x1_rr_arbiter.sv
// mux2x1_rr_arbiter: round-robin arbitrated 2:1 mux with bounded burst hold; define MUX2X1_ARB_FIXED_PRIO_EN for strict priority to requester 0
module mux2x1_rr_arbiter
    import mux2x1_rr_arbiter_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux2x1_rr_arbiter_if.slave bus
);

    localparam cnt_t LIM = cnt_t'(MAX_HOLD);

    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
        $error("MAX_HOLD must be in 1..15");
    end

    logic [1:0]       r_state;
    cnt_t             r_cnt;
    logic [1:0]       r_gnt;
    logic             r_s;
    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;

    logic [1:0]       w_nxt;
    logic [1:0]       w_idle_st;
    logic [1:0]       w_own_st;
    logic [1:0]       w_oth_st;
    cnt_t             w_cnt;
    logic             w_busy;
    logic             w_k;
    logic             w_req_own;
    logic             w_req_oth;
    logic             w_yield;
    logic             w_tie1;
    logic [WIDTH-1:0] w_y_comb;

    assign w_busy    = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_k       = (r_state == ST_OWN1);
    assign w_req_own = bus.req[w_k];
    assign w_req_oth = bus.req[~w_k];
    assign w_oth_st  = w_k ? ST_OWN0 : ST_OWN1;

`ifdef MUX2X1_ARB_FIXED_PRIO_EN
    // Requester 0 always wins: ties go to 0, OWN1 yields at once, OWN0 is never forced out
    assign w_tie1  = 1'b0;
    assign w_yield = w_k;
`else
    logic r_last;

    // Ties go to whoever did not own last; a saturated burst hands over to a waiting peer
    assign w_tie1  = ~r_last;
    assign w_yield = (r_cnt == LIM);

    // Remember the most recent owner for round-robin tie breaking
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (w_nxt == ST_OWN0 || w_nxt == ST_OWN1)
            r_last <= (w_nxt == ST_OWN1);
    end
`endif

    // Next-state and burst-count selection; an illegal encoding recovers through the idle path
    always_comb begin
        w_idle_st = bus.req == 2'b01 ? ST_OWN0 :
                    bus.req == 2'b10 ? ST_OWN1 :
                    bus.req == 2'b11 ? (w_tie1 ? ST_OWN1 : ST_OWN0) : ST_IDLE;
        w_own_st  = !w_req_own ? (w_req_oth ? w_oth_st : ST_IDLE) :
                    (w_req_oth && w_yield) ? w_oth_st : r_state;
        w_nxt     = w_busy ? w_own_st : w_idle_st;
        w_cnt     = w_nxt == ST_IDLE ? '0 :
                    w_nxt != r_state ? cnt_t'(1) : sat_inc(r_cnt, LIM);
    end

    // Arbiter state, grant and select registers; s keeps its value through idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gnt   <= 2'b00;
            r_s     <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            r_gnt   <= {w_nxt == ST_OWN1, w_nxt == ST_OWN0};
            r_s     <= w_nxt == ST_OWN1 ? 1'b1 : w_nxt == ST_OWN0 ? 1'b0 : r_s;
        end
    end

    mux2x1_word #(.WIDTH(WIDTH)) u_word (
        .s      (r_s),
        .a0     (bus.a0),
        .a1     (bus.a1),
        .y_comb (w_y_comb)
    );

    // Capture the granted word one cycle behind the grant; y holds while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y       <= w_busy ? w_y_comb : r_y;
            r_y_valid <= w_busy;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.s       = r_s;
    assign bus.y       = r_y;
    assign bus.y_valid = r_y_valid;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));
    a_gnt_sel:     assert property (@(posedge clk) disable iff (rst) (r_gnt != 2'b00) |-> (r_gnt[1] == r_s));
    a_cnt_max:     assert property (@(posedge clk) disable iff (rst) r_cnt <= LIM);
    a_state_legal: assert property (@(posedge clk) disable iff (rst) r_state != 2'd3);

endmodule
